pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM-subset core. Consumes the combinational data-hazard flag produced by the ID/EX hazard detector, the EX-stage branch-taken signal and the data-memory busy signal. Drives the PC and pipeline-register write-enables and flush (bubble) controls. The core has no forwarding paths, so a detected RAW dependency is resolved by holding IF/ID for a fixed number of cycles until the producer writes back.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and perf counter width for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int PERF_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Single-cycle update, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: Mealy enables/flushes, zero-cycle response; mem_busy_i freezes all.
// Optional perf counters built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int HAZ_STALL_CYCLES = 2,
  parameter int BR_FLUSH_CYCLES  = 1,
  parameter int CNT_W            = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              haz_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] HAZ_LOAD = CNT_W'(HAZ_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BR_LOAD  = CNT_W'(BR_FLUSH_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_busy_i) begin
      case (state)
        RUN: begin
          if (branch_taken_i) begin
            if (BR_FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = BR_LOAD;
            end
          end else if (haz_i) begin
            if (HAZ_STALL_CYCLES > 1) begin
              state_nxt = HAZ;
              cnt_nxt   = HAZ_LOAD;
            end
          end
        end
        HAZ: begin
          // A taken branch kills the stalled instruction, so the stall is abandoned.
          if (branch_taken_i) begin
            if (BR_FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = BR_LOAD;
            end else begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
            if (cnt <= 1) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end
          end
        end
        FLUSH: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt <= 1) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    idex_we    = 1'b0;
    exmem_we   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (!mem_busy_i) begin
      if ((state == FLUSH) || branch_taken_i) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if ((state == HAZ) || haz_i) begin
        // Hold PC and IF/ID; ID/EX takes a bubble while the producer drains.
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
      end
    end
  end

  assign state_o = state;

`ifdef PIPE_CTRL_PERF_EN
  logic br_go;
  logic haz_go;

  assign br_go  = reset_n && !mem_busy_i && branch_taken_i && (state != FLUSH);
  assign haz_go = reset_n && !mem_busy_i && !br_go &&
                  (((state == RUN) && haz_i) || (state == HAZ));

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .clr (!reset_n),
    .inc (haz_go),
    .cnt (stall_cnt_o)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk (clk),
    .clr (!reset_n),
    .inc (br_go),
    .cnt (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance (2-cycle stall, 1-cycle flush) and a 3-cycle-flush instance.
module tb_pipe_ctrl;

  logic clk;
  logic reset_n;
  logic haz_i;
  logic branch_taken_i;
  logic mem_busy_i;

  logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        pc_we3, ifid_we3, idex_we3, exmem_we3, ifid_flush3, idex_flush3;
  logic [1:0]  state3;
  logic [15:0] stall_cnt3, flush_cnt3;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}
  localparam logic [5:0] V_RST = 6'b000011;
  localparam logic [5:0] V_RUN = 6'b111100;
  localparam logic [5:0] V_HAZ = 6'b001101;
  localparam logic [5:0] V_BR  = 6'b111111;
  localparam logic [5:0] V_FRZ = 6'b000000;

  logic [5:0] outs, outs3;
  assign outs  = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush};
  assign outs3 = {pc_we3, ifid_we3, idex_we3, exmem_we3, ifid_flush3, idex_flush3};

  pipe_ctrl u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .haz_i          (haz_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .idex_we        (idex_we),
    .exmem_we       (exmem_we),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  pipe_ctrl #(.HAZ_STALL_CYCLES(2), .BR_FLUSH_CYCLES(3), .CNT_W(4)) u_br3 (
    .clk            (clk),
    .reset_n        (reset_n),
    .haz_i          (haz_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .pc_we          (pc_we3),
    .ifid_we        (ifid_we3),
    .idex_we        (idex_we3),
    .exmem_we       (exmem_we3),
    .ifid_flush     (ifid_flush3),
    .idex_flush     (idex_flush3),
    .state_o        (state3),
    .stall_cnt_o    (stall_cnt3),
    .flush_cnt_o    (flush_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 4 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic b, input logic m);
    haz_i          = h;
    branch_taken_i = b;
    mem_busy_i     = m;
    #4;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== V_RST || state_o !== 2'd0) begin
        errors++;
        $display("FAIL reset_outs cyc%0d: got outs=%b state=%0d, want outs=%b state=0", i, outs, state_o, V_RST);
      end
      next_cycle();
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: got outs=%b state=%0d, want outs=%b state=0", outs, state_o, V_RUN);
    end
    checks++;
    if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf: got stall=%0d flush=%0d, want 0 0", stall_cnt_o, flush_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_hazard();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== V_HAZ || state_o !== 2'd0) begin
      errors++;
      $display("FAIL haz_t: got outs=%b state=%0d, want outs=%b state=0", outs, state_o, V_HAZ);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_HAZ || state_o !== 2'd1) begin
      errors++;
      $display("FAIL haz_t1: got outs=%b state=%0d, want outs=%b state=1", outs, state_o, V_HAZ);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0 || stall_cnt_o !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL haz_t2: got outs=%b state=%0d stall=%0d, want outs=%b state=0 stall=%0d",
               outs, state_o, stall_cnt_o, V_RUN, PERF ? 2 : 0);
    end
    next_cycle();
  endtask

  task automatic test_haz_held();
    logic [1:0] exp_st [4];
    exp_st = '{2'd0, 2'd1, 2'd0, 2'd1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== V_HAZ || state_o !== exp_st[i]) begin
        errors++;
        $display("FAIL haz_held cyc%0d: got outs=%b state=%0d, want outs=%b state=%0d",
                 i, outs, state_o, V_HAZ, exp_st[i]);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0 || stall_cnt_o !== (PERF ? 16'd4 : 16'd0)) begin
      errors++;
      $display("FAIL haz_held_end: got outs=%b state=%0d stall=%0d, want outs=%b state=0 stall=%0d",
               outs, state_o, stall_cnt_o, V_RUN, PERF ? 4 : 0);
    end
    next_cycle();
  endtask

  task automatic test_branch_in_stall();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs !== V_BR || state_o !== 2'd1) begin
      errors++;
      $display("FAIL br_stall_t1: got outs=%b state=%0d, want outs=%b state=1", outs, state_o, V_BR);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0 || flush_cnt_o !== (PERF ? 16'd1 : 16'd0) ||
        stall_cnt_o !== (PERF ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL br_stall_t2: got outs=%b state=%0d flush=%0d stall=%0d, want outs=%b state=0 flush=%0d stall=%0d",
               outs, state_o, flush_cnt_o, stall_cnt_o, V_RUN, PERF ? 1 : 0, PERF ? 1 : 0);
    end
    next_cycle();
  endtask

  task automatic test_freeze();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (outs !== V_FRZ || state_o !== 2'd1) begin
        errors++;
        $display("FAIL freeze t+%0d: got outs=%b state=%0d, want outs=%b state=1", i, outs, state_o, V_FRZ);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_HAZ || state_o !== 2'd1) begin
      errors++;
      $display("FAIL freeze_resume: got outs=%b state=%0d, want outs=%b state=1", outs, state_o, V_HAZ);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0 || stall_cnt_o !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL freeze_end: got outs=%b state=%0d stall=%0d, want outs=%b state=0 stall=%0d",
               outs, state_o, stall_cnt_o, V_RUN, PERF ? 2 : 0);
    end
    next_cycle();
  endtask

  task automatic test_haz_and_branch();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs !== V_BR || state_o !== 2'd0) begin
      errors++;
      $display("FAIL haz_br_t: got outs=%b state=%0d, want outs=%b state=0", outs, state_o, V_BR);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== V_RUN || state_o !== 2'd0 || stall_cnt_o !== 16'd0 ||
        flush_cnt_o !== (PERF ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL haz_br_t1: got outs=%b state=%0d stall=%0d flush=%0d, want outs=%b state=0 stall=0 flush=%0d",
               outs, state_o, stall_cnt_o, flush_cnt_o, V_RUN, PERF ? 1 : 0);
    end
    next_cycle();
  endtask

  task automatic test_flush3();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs3 !== V_BR || state3 !== 2'd0) begin
      errors++;
      $display("FAIL br3_t: got outs=%b state=%0d, want outs=%b state=0", outs3, state3, V_BR);
    end
    next_cycle();
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (outs3 !== V_BR || state3 !== 2'd2) begin
        errors++;
        $display("FAIL br3 t+%0d: got outs=%b state=%0d, want outs=%b state=2", i, outs3, state3, V_BR);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs3 !== V_RUN || state3 !== 2'd0 || stall_cnt3 !== 16'd0 ||
        flush_cnt3 !== (PERF ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL br3_end: got outs=%b state=%0d stall=%0d flush=%0d, want outs=%b state=0 stall=0 flush=%0d",
               outs3, state3, stall_cnt3, flush_cnt3, V_RUN, PERF ? 1 : 0);
    end
    next_cycle();
  endtask

  initial begin
    reset_n        = 1'b0;
    haz_i          = 1'b0;
    branch_taken_i = 1'b0;
    mem_busy_i     = 1'b0;
    next_cycle();
    test_reset();
    test_hazard();
    test_haz_held();
    test_branch_in_stall();
    test_freeze();
    test_haz_and_branch();
    test_flush3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
